fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the 4-bit CPU; the requesting end of the instruction memory read interface.
- Drives the 4-bit PC into the combinational 16x9 instruction memory and registers the returned 9-bit word into an instruction register.
- Presents the word to decode over a valid/ready handshake.
- Handles jumps (PC load plus flush), halt-word detection, run/stop control and a saturating fetch counter.

Parameters:
- HALT_INS, 9'h0C0: instruction word that halts fetching (the fill word for unused memory).
- CNT_W, 8: width of the fetch counter.

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- PC  out  4  address to instruction memory
- RES_INS  in  9  instruction memory data; combinational function of PC, valid in the same cycle
- INS  out  9  registered instruction to decode
- INS_VALID  out  1  INS holds an unconsumed instruction
- INS_READY  in  1  decode accepts INS this cycle
- JMP_EN  in  1  one-cycle jump request from execute
- JMP_ADDR  in  4  jump target
- RUN  in  1  level; 1 = fetch enabled
- HALTED  out  1  fetch unit is in the HALT state
- FETCH_CNT  out  CNT_W  number of instructions captured, saturating

Behaviour:
- Reset (async assert, synchronous release):
  - PC=0, INS=0, INS_VALID=0, HALTED=0, FETCH_CNT=0, state=IDLE.
  - Reset mid-operation discards INS and any pending jump.
- States: IDLE, FETCH, HALT.
- Handshake:
  - A transfer occurs on a rising edge with INS_VALID=1 and INS_READY=1.
  - INS and INS_VALID never change while INS_VALID=1 and INS_READY=0, unless JMP_EN flushes.
- Capture condition, evaluated in FETCH with JMP_EN=0: INS_VALID=0, or a transfer occurs this cycle. On capture:
  - INS<=RES_INS, INS_VALID<=1, FETCH_CNT<=FETCH_CNT+1 (saturating at all ones).
  - If RES_INS!=HALT_INS: PC<=PC+1 with 4-bit wrap (15->0).
  - If RES_INS==HALT_INS: PC holds, state<=HALT.
  - Throughput is one instruction per cycle with decode always ready.
  - Latency is 1 cycle from PC to INS_VALID.
- If a transfer occurs without a capture, INS_VALID<=0.
- IDLE:
  - No capture. Any outstanding INS stays valid until transferred.
  - RUN=1 -> FETCH next cycle; the first capture happens in the following cycle.
- FETCH:
  - RUN=0 -> IDLE. No capture occurs in that cycle, and PC holds.
- HALT:
  - HALTED=1, no capture. The halt word itself stays valid until transferred.
  - RUN is ignored.
  - Exit only via JMP_EN or reset.
- JMP_EN=1, any state, highest priority:
  - PC<=JMP_ADDR, INS_VALID<=0 (flush, even if a transfer occurs the same edge), no capture, FETCH_CNT unchanged.
  - Next state is FETCH if RUN=1, else IDLE. HALTED clears.
- Simultaneous JMP_EN and HALT_INS at RES_INS: the jump wins and HALT is not entered.
- JMP_ADDR equal to the current PC is legal and refetches that word.

Decomposition:
- Shared package cpu_pkg holds:
  - INS_W=9, PC_W=4.
  - HALT_INS constant 9'h0C0.
  - State enum FETCH_IDLE/FETCH_RUN/FETCH_HALT.
- No sub-module. The PC incrementer and saturating counter are inline.
- The top level instantiates fetch_unit driving ins_mem.PC and receiving ins_mem.RES_INS.

Test Plan:
- Run with ready: reset, RUN=1, INS_READY=1, memory words 0x086, 0x09D, 0x021, 0x0C0 -> INS sequence 0x086, 0x09D, 0x021, 0x0C0, one per cycle. HALTED=1 after 0x0C0, PC=3, FETCH_CNT=4.
- Backpressure: INS_READY=0 for 3 cycles after first capture -> INS=0x086 stable, PC=1, FETCH_CNT=1. Release -> 0x09D on the next cycle.
- Jump flush: INS_VALID=1 holding 0x021 at PC=3, assert JMP_EN with JMP_ADDR=0 -> INS_VALID=0 next cycle, PC=0, next INS=0x086. FETCH_CNT is not incremented by the jump.
- Halt exit: in HALT, RUN toggled -> no change. JMP_EN with JMP_ADDR=1 -> HALTED=0, next INS=0x09D.
- Wrap and stop: a memory with no halt word, run 17 captures -> PC wraps 15->0->1. RUN=0 mid-stream -> PC frozen, last INS held until consumed.
- Async reset mid-stream: RST_N low between edges -> PC=0, INS_VALID=0, FETCH_CNT=0 immediately. After release with RUN=1, fetch restarts at PC 0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths, halt word and fetch-state encoding for the
//                4-bit CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Instruction word and program counter widths
  localparam int unsigned INS_W = 9;
  localparam int unsigned PC_W  = 4;

  // Fill word of unused instruction memory; fetching it stops the fetch unit
  localparam logic [INS_W-1:0] DEFAULT_HALT_INS = 9'h0C0;

  // Fetch unit state encoding
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t FETCH_IDLE = 2'd0;
  localparam fetch_state_t FETCH_RUN  = 2'd1;
  localparam fetch_state_t FETCH_HALT = 2'd2;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Program counter and instruction fetch stage. Addresses the
//                combinational instruction memory, registers the returned word
//                and offers it to decode over a valid/ready handshake. Handles
//                jumps with flush, halt-word detection, run/stop control and a
//                saturating fetch counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [INS_W-1:0] HALT_INS = DEFAULT_HALT_INS,
  parameter int unsigned      CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   pc,
  input  logic [INS_W-1:0]  res_ins,
  output logic [INS_W-1:0]  ins,
  output logic              ins_valid,
  input  logic              ins_ready,
  input  logic              jmp_en,
  input  logic [PC_W-1:0]   jmp_addr,
  input  logic              run,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam logic [PC_W-1:0]  c_pc_one  = PC_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  fetch_state_t     r_state;
  logic [PC_W-1:0]  r_pc;
  logic [INS_W-1:0] r_ins;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  logic w_transfer;
  logic w_capture;
  logic w_is_halt;

  // Decode consumes the held word this edge
  assign w_transfer = r_valid & ins_ready;

  // A new word is taken only while running, with no jump, and with the
  // register either empty or being emptied on the same edge
  assign w_capture = (r_state == FETCH_RUN) & run & ~jmp_en & (~r_valid | ins_ready);

  assign w_is_halt = (res_ins == HALT_INS);

  // Next-state logic; a jump overrides everything, including HALT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH_IDLE;
    end else if (jmp_en) begin
      r_state <= run ? FETCH_RUN : FETCH_IDLE;
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          if (run) r_state <= FETCH_RUN;
        end
        FETCH_RUN: begin
          if (!run)                      r_state <= FETCH_IDLE;
          else if (w_capture && w_is_halt) r_state <= FETCH_HALT;
        end
        FETCH_HALT: begin
          r_state <= FETCH_HALT;
        end
        default: begin
          r_state <= FETCH_IDLE;
        end
      endcase
    end
  end

  // Program counter: jump load, or advance past every captured non-halt word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (jmp_en) begin
      r_pc <= jmp_addr;
    end else if (w_capture && !w_is_halt) begin
      r_pc <= r_pc + c_pc_one;
    end
  end

  // Instruction register; the data only moves on capture, valid also drops
  // on flush or on a transfer that is not refilled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ins   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_capture) r_ins <= res_ins;
      if (jmp_en)          r_valid <= 1'b0;
      else if (w_capture)  r_valid <= 1'b1;
      else if (w_transfer) r_valid <= 1'b0;
    end
  end

  // Saturating count of captured instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_capture && (r_cnt != '1)) begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  assign pc        = r_pc;
  assign ins       = r_ins;
  assign ins_valid = r_valid;
  assign halted    = (r_state == FETCH_HALT);
  assign fetch_cnt = r_cnt;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with a behavioural model
//                and a combinational 16-word instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int CNT_W  = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       pc;
  logic [8:0]       res_ins;
  logic [8:0]       ins;
  logic             ins_valid;
  logic             ins_ready = 1'b0;
  logic             jmp_en = 1'b0;
  logic [3:0]       jmp_addr = 4'd0;
  logic             run = 1'b0;
  logic             halted;
  logic [CNT_W-1:0] fetch_cnt;

  logic [8:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference state
  int         m_pc;
  int         m_mode;
  int         m_cnt;
  logic [8:0] m_ins;
  bit         m_valid;

  always #5 clk = ~clk;

  assign res_ins = mem[pc];

  fetch_unit #(
    .HALT_INS (9'h0C0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .res_ins   (res_ins),
    .ins       (ins),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .jmp_en    (jmp_en),
    .jmp_addr  (jmp_addr),
    .run       (run),
    .halted    (halted),
    .fetch_cnt (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_mode = M_IDLE; m_cnt = 0; m_ins = '0; m_valid = 0;
  endtask

  // One clock edge of the fetch rules, from the current inputs
  task automatic model_step();
    bit xfer;
    xfer = m_valid && ins_ready;
    if (jmp_en) begin
      m_pc    = int'(jmp_addr);
      m_valid = 0;
      m_mode  = run ? M_RUN : M_IDLE;
    end else if (m_mode == M_RUN && run && (!m_valid || ins_ready)) begin
      m_ins   = mem[m_pc];
      m_valid = 1;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (m_ins == 9'h0C0) m_mode = M_HALT;
      else                 m_pc = (m_pc + 1) % 16;
    end else begin
      if (xfer) m_valid = 0;
      if (m_mode == M_IDLE && run)      m_mode = M_RUN;
      else if (m_mode == M_RUN && !run) m_mode = M_IDLE;
    end
  endtask

  task automatic compare_model();
    check("model_pc",     pc,        m_pc);
    check("model_valid",  ins_valid, m_valid);
    check("model_ins",    ins,       m_ins);
    check("model_halted", halted,    m_mode == M_HALT);
    check("model_cnt",    fetch_cnt, m_cnt);
  endtask

  // Drive inputs on the falling edge, advance the model, check after the edge
  task automatic cycle(input logic r, input logic rd, input logic j, input logic [3:0] ja);
    @(negedge clk);
    run = r; ins_ready = rd; jmp_en = j; jmp_addr = ja;
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  // Asynchronous reset between edges, released on a falling edge
  task automatic async_reset();
    #2;
    run = 1'b0; jmp_en = 1'b0; ins_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pc",     pc,        0);
    check("rst_valid",  ins_valid, 0);
    check("rst_cnt",    fetch_cnt, 0);
    check("rst_halted", halted,    0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 9'h0C0;
    mem[0] = 9'h086; mem[1] = 9'h09D; mem[2] = 9'h021; mem[3] = 9'h0C0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    compare_model();
    check("reset_ins", ins, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // Run with decode always ready
    cycle(1'b1, 1'b1, 1'b0, 4'd0);
    check("idle_to_fetch_valid", ins_valid, 0);
    cycle(1'b1, 1'b1, 1'b0, 4'd0); check("run_ins0", ins, 9'h086);
    cycle(1'b1, 1'b1, 1'b0, 4'd0); check("run_ins1", ins, 9'h09D);
    cycle(1'b1, 1'b1, 1'b0, 4'd0); check("run_ins2", ins, 9'h021);
    cycle(1'b1, 1'b1, 1'b0, 4'd0);
    check("run_ins3",    ins,       9'h0C0);
    check("halt_flag",   halted,    1);
    check("halt_pc",     pc,        3);
    check("halt_cnt",    fetch_cnt, 4);

    // HALT ignores RUN; halt word stays valid until taken
    cycle(1'b0, 1'b0, 1'b0, 4'd0);
    check("halt_hold_valid", ins_valid, 1);
    check("halt_hold_ins",   ins,       9'h0C0);
    cycle(1'b1, 1'b1, 1'b0, 4'd0);
    check("halt_still",      halted,    1);
    check("halt_pc_frozen",  pc,        3);

    // Exit HALT by jump to 1
    cycle(1'b1, 1'b1, 1'b1, 4'd1);
    check("jmp_exit_halted", halted, 0);
    check("jmp_exit_pc",     pc,     1);
    cycle(1'b1, 1'b1, 1'b0, 4'd0); check("jmp_exit_ins", ins, 9'h09D);

    // Jump flush while holding 0x021 at PC=3
    cycle(1'b1, 1'b1, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 1'b0, 4'd0);
    check("flush_pre_ins", ins, 9'h021);
    check("flush_pre_pc",  pc,  3);
    cycle(1'b1, 1'b0, 1'b1, 4'd0);
    check("flush_valid", ins_valid, 0);
    check("flush_pc",    pc,        0);
    check("flush_cnt",   fetch_cnt, 6);
    cycle(1'b1, 1'b1, 1'b0, 4'd0); check("flush_refetch", ins, 9'h086);

    // Backpressure
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 4'd0);
      check("bp_ins", ins, 9'h086);
      check("bp_pc",  pc,  1);
    end
    cycle(1'b1, 1'b1, 1'b0, 4'd0); check("bp_release", ins, 9'h09D);

    // Wrap and stop with a memory containing no halt word
    async_reset();
    for (int i = 0; i < 16; i++) mem[i] = 9'(9'h010 + i);
    cycle(1'b1, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 17; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 4'd0);
      if (k == 16) begin
        check("wrap_pc16",  pc,  0);
        check("wrap_ins16", ins, 9'h01F);
      end
      if (k == 17) check("wrap_pc17", pc, 1);
    end
    cycle(1'b0, 1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b0, 1'b0, 4'd0);
    check("stop_pc",    pc,        1);
    check("stop_ins",   ins,       9'h010);
    check("stop_valid", ins_valid, 1);
    cycle(1'b0, 1'b1, 1'b0, 4'd0);
    check("stop_drain", ins_valid, 0);

    // Restart after reset fetches from address 0
    async_reset();
    cycle(1'b1, 1'b1, 1'b0, 4'd0);
    cycle(1'b1, 1'b1, 1'b0, 4'd0);
    check("restart_ins", ins, 9'h010);
    check("restart_pc",  pc,  1);

    // Randomised traffic against the model
    for (int blk = 0; blk < 3; blk++) begin
      async_reset();
      for (int i = 0; i < 16; i++)
        mem[i] = ($urandom_range(0, 5) == 0) ? 9'h0C0 : 9'($urandom_range(0, 511));
      for (int k = 0; k < 150; k++)
        cycle(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
              ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
              ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
              4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
